// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a shared-memory RV32I datapath.
// Define MC_PERF_CNT_EN to build the cycle and retired-instruction counters.
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    C_ALU    = 2'd0,
    C_LOAD   = 2'd1,
    C_STORE  = 2'd2,
    C_BRANCH = 2'd3
  } cls_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  cls_t                cls_q, cls_d, dec_cls;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                legal, wait_hit;
  logic                ireq, dreq, dwe, irw, pcw, rw;

  always_comb begin
    dec_cls = C_ALU;
    legal   = 1'b1;
    case (Op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111: dec_cls = C_ALU;
      7'b1100111: legal   = (Funct3 == 3'b000);
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      default:    legal   = 1'b0;
    endcase
  end

  // The wait budget expires on the cycle where the TIMEOUT-th unready cycle is seen.
  assign wait_hit = (wait_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    wait_d  = wait_q;
    ireq    = 1'b0;
    dreq    = 1'b0;
    dwe     = 1'b0;
    irw     = 1'b0;
    pcw     = 1'b0;
    rw      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        ireq = 1'b1;
        if (imem_ready) begin
          irw     = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        cls_d   = dec_cls;
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (cls_q == C_LOAD || cls_q == C_STORE) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (cls_q == C_BRANCH) begin
          pcw = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dreq = 1'b1;
        dwe  = (cls_q == C_STORE);
        if (dmem_ready) begin
          if (cls_q == C_STORE) pcw = 1'b1;
          else                  state_d = S_WB;
        end else if (wait_hit) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        rw  = 1'b1;
        pcw = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    // Every retire path funnels through here to pick the next instruction or stop.
    if (pcw) begin
      state_d = run ? S_FETCH : S_IDLE;
      wait_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cls_q   <= C_ALU;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
    end
  end

  // A reset cycle suppresses every request and strobe before the state clears.
  assign imem_req = rstn & ireq;
  assign dmem_req = rstn & dreq;
  assign dmem_we  = rstn & dwe;
  assign IRWrite  = rstn & irw;
  assign PCWrite  = rstn & pcw;
  assign RegWrite = rstn & rw;
  assign state    = state_q;
  assign trap     = (state_q == S_TRAP);

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (PCWrite) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: each instruction is expanded into its expected
// cycle timeline from the latency/wait rules, then replayed against the DUT.
module tb_mc_ctrl_fsm;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef struct {
    logic [2:0] st;
    bit ireq, dreq, dwe, irw, pcw, rw;
    bit ir, dr, rn;
  } cyc_t;

  logic             clk = 1'b0;
  logic             rstn, run, imem_ready, dmem_ready;
  logic [6:0]       Op;
  logic [2:0]       Funct3;
  logic             imem_req, dmem_req, dmem_we, IRWrite, PCWrite, RegWrite, trap;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int               checks = 0;
  int               failures = 0;
  int               cur_state = 0;
  logic [CNT_W-1:0] exp_cyc = '0;
  logic [CNT_W-1:0] exp_ins = '0;

  mc_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .run(run), .Op(Op), .Funct3(Funct3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .state(state), .trap(trap), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(input logic [2:0] st, input bit ireq, input bit dreq, input bit dwe,
                              input bit irw, input bit pcw, input bit rw,
                              input bit ir, input bit dr, input bit rn);
    cyc_t c;
    c.st = st; c.ireq = ireq; c.dreq = dreq; c.dwe = dwe;
    c.irw = irw; c.pcw = pcw; c.rw = rw; c.ir = ir; c.dr = dr; c.rn = rn;
    return c;
  endfunction

  // Drive one cycle, compare outputs mid-cycle, then advance the counter model.
  task automatic apply_stimulus(input cyc_t c, input logic rs);
    logic [9:0] exp_vec;
    rstn = rs; run = c.rn; imem_ready = c.ir; dmem_ready = c.dr;
    #1;
    exp_vec = {c.st, rs & c.ireq, rs & c.dreq, rs & c.dwe, rs & c.irw,
               rs & c.pcw, rs & c.rw, c.st == 3'd6};
    check_output("outputs", 64'({state, imem_req, dmem_req, dmem_we, IRWrite,
                                 PCWrite, RegWrite, trap}), 64'(exp_vec));
`ifdef MC_PERF_CNT_EN
    check_output("cycle_cnt", 64'(cycle_cnt), 64'(exp_cyc));
    check_output("instret_cnt", 64'(instret_cnt), 64'(exp_ins));
`else
    check_output("cycle_cnt", 64'(cycle_cnt), 64'd0);
    check_output("instret_cnt", 64'(instret_cnt), 64'd0);
`endif
    @(posedge clk);
    if (!rs) begin
      exp_cyc = '0;
      exp_ins = '0;
    end else begin
      if (c.st != 3'd0 && c.st != 3'd6) exp_cyc = exp_cyc + 1'b1;
      if (c.pcw) exp_ins = exp_ins + 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply_stimulus(mk(3'(cur_state), 0, 0, 0, 0, 0, 0, rb(), rb(), rb()), 1'b0);
    cur_state = 0;
  endtask

  // Builds the expected timeline for one instruction, then replays it.
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input int iw,
                          input int dw, input bit run_after, input int abort_at);
    cyc_t q[$];
    bit is_ld, is_st, is_br, legal, trapped;
    is_ld = (op == OP_LD);
    is_st = (op == OP_ST);
    is_br = (op == OP_BR);
    legal = (op == OP_ALU) || (op == OP_ALUI) || is_ld || is_st || is_br ||
            (op == OP_LUI) || (op == OP_JAL) || ((op == OP_JALR) && (f3 == 3'b000));
    trapped = 1'b0;
    Op = op;
    Funct3 = f3;
    if (cur_state == 0) begin
      repeat ($urandom_range(0, 2)) q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, rb(), rb(), 1'b0));
      q.push_back(mk(3'd0, 0, 0, 0, 0, 0, 0, rb(), rb(), 1'b1));
    end
    if (iw >= TIMEOUT) begin
      repeat (TIMEOUT) q.push_back(mk(3'd1, 1, 0, 0, 0, 0, 0, 1'b0, rb(), rb()));
      trapped = 1'b1;
    end else begin
      repeat (iw) q.push_back(mk(3'd1, 1, 0, 0, 0, 0, 0, 1'b0, rb(), rb()));
      q.push_back(mk(3'd1, 1, 0, 0, 1, 0, 0, 1'b1, rb(), rb()));
      q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, rb(), rb(), rb()));
      if (!legal) trapped = 1'b1;
    end
    if (!trapped) begin
      if (is_br) begin
        q.push_back(mk(3'd3, 0, 0, 0, 0, 1, 0, rb(), rb(), run_after));
      end else if (is_ld || is_st) begin
        q.push_back(mk(3'd3, 0, 0, 0, 0, 0, 0, rb(), rb(), rb()));
        if (dw >= TIMEOUT) begin
          repeat (TIMEOUT) q.push_back(mk(3'd4, 0, 1, is_st, 0, 0, 0, rb(), 1'b0, rb()));
          trapped = 1'b1;
        end else begin
          repeat (dw) q.push_back(mk(3'd4, 0, 1, is_st, 0, 0, 0, rb(), 1'b0, rb()));
          q.push_back(mk(3'd4, 0, 1, is_st, 0, is_st, 0, rb(), 1'b1, is_st ? run_after : rb()));
          if (is_ld) q.push_back(mk(3'd5, 0, 0, 0, 0, 1, 1, rb(), rb(), run_after));
        end
      end else begin
        q.push_back(mk(3'd3, 0, 0, 0, 0, 0, 0, rb(), rb(), rb()));
        q.push_back(mk(3'd5, 0, 0, 0, 0, 1, 1, rb(), rb(), run_after));
      end
    end
    foreach (q[i]) begin
      if (i == abort_at) begin
        apply_stimulus(q[i], 1'b0);
        cur_state = 0;
        return;
      end
      apply_stimulus(q[i], 1'b1);
    end
    if (trapped) begin
      repeat (20) apply_stimulus(mk(3'd6, 0, 0, 0, 0, 0, 0, rb(), rb(), rb()), 1'b1);
      apply_stimulus(mk(3'd6, 0, 0, 0, 0, 0, 0, rb(), rb(), rb()), 1'b0);
      cur_state = 0;
    end else begin
      cur_state = run_after ? 1 : 0;
    end
  endtask

  initial begin
    logic [6:0] ops [11];
    int         pick, iw, dw, ab;
    ops = '{OP_ALU, OP_ALUI, OP_LD, OP_ST, OP_BR, OP_LUI, OP_JAL, OP_JALR,
            7'b0000000, 7'b1110011, 7'b0001111};
    rstn = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    Op = '0; Funct3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply_stimulus(mk(3'd0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0), 1'b0);

    do_instr(OP_ALU, 3'b000, 0, 0, 1'b1, -1);
    do_instr(OP_LD, 3'b010, 0, 3, 1'b1, -1);
    do_instr(OP_ST, 3'b010, 0, 0, 1'b1, -1);
    do_instr(OP_BR, 3'b000, 0, 0, 1'b0, -1);
    do_instr(7'b0000000, 3'b000, 0, 0, 1'b1, -1);
    do_instr(OP_JALR, 3'b001, 0, 0, 1'b1, -1);
    do_instr(OP_ALU, 3'b000, TIMEOUT, 0, 1'b1, -1);
    do_instr(OP_ALU, 3'b000, TIMEOUT - 1, 0, 1'b1, -1);
    do_instr(OP_ST, 3'b000, 0, TIMEOUT - 1, 1'b1, -1);
    do_instr(OP_LD, 3'b000, 0, TIMEOUT, 1'b1, -1);
    do_instr(OP_LD, 3'b000, 1, 2, 1'b0, -1);
    do_instr(OP_LD, 3'b000, 0, 4, 1'b1, 6);

    do_reset();
    for (int n = 0; n < 10; n++) do_instr(OP_ALUI, 3'b000, 0, 0, n != 9, -1);
`ifdef MC_PERF_CNT_EN
    check_output("perf_instret_10", 64'(instret_cnt), 64'd10);
    check_output("perf_cycle_40", 64'(cycle_cnt), 64'd40);
`endif

    for (int n = 0; n < 120; n++) begin
      pick = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 10) : $urandom_range(0, 7);
      iw = ($urandom_range(0, 15) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 15) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 3);
      ab = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 8) : -1;
      do_instr(ops[pick], 3'($urandom_range(0, 7)) & (($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000),
               iw, dw, $urandom_range(0, 3) != 0, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
